// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors of a 4-input gate, captures its truth table and compares it with EXPECTED.
// Optional failure log (fail_idx/fail_seen) is enabled by defining TRUTH_TABLE_SWEEPER_FAIL_LOG_EN.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h0239
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  gate_in,
    input  logic        gate_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
    ,
    output logic [3:0]  fail_idx,
    output logic        fail_seen
`endif
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] index;
    logic [7:0] settle_cnt;

    assign gate_in = index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = APPLY;
            end
            APPLY: begin
                busy = 1'b1;
                if (abort)                 state_next = IDLE;
                else if (settle_cnt == '0) state_next = SAMPLE;
            end
            SAMPLE: begin
                busy = 1'b1;
                if (abort)              state_next = IDLE;
                else if (index == 4'hF) state_next = DONE;
                else                    state_next = APPLY;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // pass is resolved on the last capture so it is already valid while done is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index      <= '0;
            settle_cnt <= '0;
            table_out  <= '0;
            pass       <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
            fail_idx   <= '0;
            fail_seen  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        table_out  <= '0;
                        index      <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= SETTLE_RELOAD;
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
                        fail_idx   <= '0;
                        fail_seen  <= 1'b0;
`endif
                    end
                end
                APPLY: begin
                    if (!abort && settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
                end
                SAMPLE: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        table_out[index] <= gate_out;
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
                        if (!fail_seen && (gate_out != EXPECTED[index])) begin
                            fail_idx  <= index;
                            fail_seen <= 1'b1;
                        end
`endif
                        if (index == 4'hF) begin
                            pass <= ({gate_out, table_out[14:0]} == EXPECTED);
                        end else begin
                            index      <= index + 4'd1;
                            settle_cnt <= SETTLE_RELOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
